write_hit_ctrl: RTL and testbench
=================================

// Module: write_hit_ctrl
// PURPOSE
//  Write-hit check controller, directly upstream of the synchronous-read RAMs.
//  Takes a write request (tag+index, data) and reads tag RAM {valid,tag} at index.
//  On a hit, writes data into the data RAM; always reports hit/miss to the requester.
//  Drives a tag RAM (TAG_W+1 wide) and a data RAM (DWIDTH wide), each INDEX_W addressed
//  with 1-cycle read latency: address sampled at posedge, dout valid the next cycle.
// PARAMETERS
//  INDEX_W  3   index bits = RAM address width
//  TAG_W    8   tag bits; req_addr width = TAG_W+INDEX_W
//  DWIDTH   32  write data width
//  CNT_W    16  hit/miss statistics counter width
// PORTS
//  clock      in   1               single clock, all state on posedge
//  reset_n    in   1               asynchronous active-low reset
//  req_valid  in   1               write request valid
//  req_ready  out  1               high only in IDLE
//  req_addr   in   TAG_W+INDEX_W   {tag, index}
//  req_data   in   DWIDTH          write data
//  resp_valid out  1               result valid, held until resp_ready
//  resp_ready in   1               requester accepts result
//  resp_hit   out  1               1 = hit (data written), 0 = miss
//  tag_addr   out  INDEX_W         tag RAM address (registered index)
//  tag_din    out  TAG_W+1         {1'b1, tag} (used only by allocate)
//  tag_we     out  1               tag RAM write enable
//  tag_dout   in   TAG_W+1         tag RAM read data, MSB = valid
//  data_addr  out  INDEX_W         data RAM address (= tag_addr)
//  data_din   out  DWIDTH          registered req_data
//  data_we    out  1               data RAM write enable, one cycle per write
//  hit_cnt    out  CNT_W           saturating hit count
//  miss_cnt   out  CNT_W           saturating miss count
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE; every output 0 except req_ready=1;
//    captured tag/index/data and counters cleared. A write in flight is dropped;
//    RAM contents untouched.
//  - FSM: IDLE -> LOOKUP -> COMPARE -> (WRITE | RESP) ; WRITE -> RESP ; RESP -> IDLE.
//  - IDLE: req_ready=1; req_valid&req_ready captures tag, index, data -> LOOKUP.
//  - LOOKUP: tag_addr=index, tag_we=0; RAM samples address at this edge -> COMPARE.
//  - COMPARE: hit = tag_dout[TAG_W] & (tag_dout[TAG_W-1:0]==tag_q).
//    hit -> WRITE, hit_cnt+1; miss -> RESP, miss_cnt+1 (both saturate at all-ones).
//  - WRITE: data_we=1 for exactly one cycle, data_addr=index, data_din=data_q -> RESP.
//  - RESP: resp_valid=1, resp_hit stable; on resp_ready -> IDLE (resp_valid drops).
//  - Latency, accept edge to resp_valid high: hit 3 clocks, miss 2 clocks.
//    Min turnaround back-to-back: hit 5 clocks, miss 4 clocks.
//  - No new request accepted outside IDLE; resp_ready outside RESP is ignored.
//  - X on tag_dout in COMPARE (unwritten RAM) counts as miss; no write issued.
// CONFIGURATION
//  WRITE_ALLOCATE_EN defined: a miss goes COMPARE->WRITE with tag_we=1,
//    tag_din={1'b1,tag_q}, data_we=1 same cycle; resp_hit stays 0; miss_cnt+1.
//  Not defined: tag_we tied 0, tag_din tied 0; miss writes nothing.
// TESTING
//  1 tag RAM[5]={1,0xA3}; req addr={0xA3,5}, data=0xDEADBEEF -> resp_hit=1 after 3 clk,
//    one data_we pulse, data RAM[5]=0xDEADBEEF, hit_cnt=1.
//  2 tag RAM[2]={0,0x11}; req {0x11,2} -> resp_hit=0 after 2 clk, no data_we,
//    miss_cnt=1; with WRITE_ALLOCATE_EN tag RAM[2]={1,0x11}, data written.
//  3 hit, resp_ready held low 10 clk -> resp_valid/resp_hit stable, req_ready=0,
//    req_valid ignored; release -> IDLE next clk.
//  4 reset_n low in WRITE state -> next sample: data_we=0, req_ready=1, counters 0,
//    data RAM unchanged.
//  5 CNT_W=2, 5 hits -> hit_cnt 1,2,3,3,3 (saturates); miss_cnt stays 0.
//  6 Index wrap: req {tag,7} then {tag,0} back-to-back -> correct RAM entries, no alias.

Source files
------------

// File: rtl/write_hit_ctrl_if.sv
// rtl/write_hit_ctrl_if.sv - requester-side request/response handshake for write_hit_ctrl
interface write_hit_ctrl_if #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 8,
    parameter int DWIDTH  = 32
);
    logic                     req_valid;
    logic                     req_ready;
    logic [TAG_W+INDEX_W-1:0] req_addr;
    logic [DWIDTH-1:0]        req_data;
    logic                     resp_valid;
    logic                     resp_ready;
    logic                     resp_hit;

    modport master (
        output req_valid, req_addr, req_data, resp_ready,
        input  req_ready, resp_valid, resp_hit
    );

    modport slave (
        input  req_valid, req_addr, req_data, resp_ready,
        output req_ready, resp_valid, resp_hit
    );
endinterface

// File: rtl/write_hit_ctrl.sv
// rtl/write_hit_ctrl.sv - write-hit check controller in front of sync-read tag/data RAMs
// Optional WRITE_ALLOCATE_EN: a miss installs the tag and writes the data in the same cycle.
module write_hit_ctrl #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 8,
    parameter int DWIDTH  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    write_hit_ctrl_if.slave    bus,
    output logic [INDEX_W-1:0] tag_addr,
    output logic [TAG_W:0]     tag_din,
    output logic               tag_we,
    input  logic [TAG_W:0]     tag_dout,
    output logic [INDEX_W-1:0] data_addr,
    output logic [DWIDTH-1:0]  data_din,
    output logic               data_we,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        COMPARE = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic [DWIDTH-1:0]  data_q;
    logic               hit;

    // An X from an unwritten RAM entry fails the if() below and falls to the miss path.
    assign hit = tag_dout[TAG_W] & (tag_dout[TAG_W-1:0] == tag_q);

    assign tag_addr  = index_q;
    assign data_addr = index_q;
    assign data_din  = data_q;

`ifndef WRITE_ALLOCATE_EN
    assign tag_we  = 1'b0;
    assign tag_din = '0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tag_q          <= '0;
            index_q        <= '0;
            data_q         <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_hit   <= 1'b0;
            data_we        <= 1'b0;
            hit_cnt        <= '0;
            miss_cnt       <= '0;
`ifdef WRITE_ALLOCATE_EN
            tag_we         <= 1'b0;
            tag_din        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        tag_q         <= bus.req_addr[TAG_W+INDEX_W-1:INDEX_W];
                        index_q       <= bus.req_addr[INDEX_W-1:0];
                        data_q        <= bus.req_data;
                        bus.req_ready <= 1'b0;
                        state         <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        bus.resp_hit <= 1'b1;
                        data_we      <= 1'b1;
                        if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 1'b1;
                        state        <= WRITE;
                    end else begin
                        bus.resp_hit <= 1'b0;
                        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + 1'b1;
`ifdef WRITE_ALLOCATE_EN
                        tag_we       <= 1'b1;
                        tag_din      <= {1'b1, tag_q};
                        data_we      <= 1'b1;
                        state        <= WRITE;
`else
                        bus.resp_valid <= 1'b1;
                        state          <= RESP;
`endif
                    end
                end
                WRITE: begin
                    data_we        <= 1'b0;
`ifdef WRITE_ALLOCATE_EN
                    tag_we         <= 1'b0;
`endif
                    bus.resp_valid <= 1'b1;
                    state          <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_write_hit_ctrl.sv
// tb/tb_write_hit_ctrl.sv - scoreboard bench for write_hit_ctrl with behavioural RAMs
module tb_write_hit_ctrl;
    localparam int INDEX_W = 3;
    localparam int TAG_W   = 8;
    localparam int DWIDTH  = 32;
    localparam int CNT_W   = 2;

`ifdef WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic [INDEX_W-1:0] tag_addr, data_addr;
    logic [TAG_W:0]     tag_din, tag_dout;
    logic               tag_we, data_we;
    logic [DWIDTH-1:0]  data_din;
    logic [CNT_W-1:0]   hit_cnt, miss_cnt;

    write_hit_ctrl_if #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DWIDTH(DWIDTH)) bus ();

    write_hit_ctrl #(.INDEX_W(INDEX_W), .TAG_W(TAG_W), .DWIDTH(DWIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .tag_addr(tag_addr), .tag_din(tag_din), .tag_we(tag_we), .tag_dout(tag_dout),
        .data_addr(data_addr), .data_din(data_din), .data_we(data_we),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clock = ~clock;

    logic [TAG_W:0]     tag_ram  [0:7];
    logic [DWIDTH-1:0]  data_ram [0:7];
    logic               pl_en = 1'b0;
    logic [INDEX_W-1:0] pl_addr = '0;
    logic [TAG_W:0]     pl_tag = '0;
    logic [DWIDTH-1:0]  pl_data = '0;
    int                 we_cnt = 0;
    int                 cyc = 0;

    // Synchronous-read RAMs; the preload port lets the bench seed entries without a second driver.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (pl_en) begin
            tag_ram[pl_addr]  <= pl_tag;
            data_ram[pl_addr] <= pl_data;
        end else begin
            if (tag_we) tag_ram[tag_addr] <= tag_din;
            if (data_we) begin
                data_ram[data_addr] <= data_din;
                we_cnt <= we_cnt + 1;
            end
        end
        tag_dout <= tag_ram[tag_addr];
    end

    typedef struct {
        logic             hit;
        int               lat;
        int               acc;
        logic [CNT_W-1:0] hc;
        logic [CNT_W-1:0] mc;
    } exp_t;

    exp_t             exp_q[$];
    int               n_tests = 0;
    int               n_fail = 0;
    logic [CNT_W-1:0] m_hc = '0;
    logic [CNT_W-1:0] m_mc = '0;
    int               exp_we = 0;
    logic             prev_rv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Monitor: every new response is popped against the scoreboard.
    always @(negedge clock) begin
        if (bus.resp_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
                bound_fail("unexpected_resp");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_hit", bus.resp_hit, e.hit);
                chk("latency", cyc - e.acc, e.lat);
                chk("hit_cnt", hit_cnt, e.hc);
                chk("miss_cnt", miss_cnt, e.mc);
            end
        end
        prev_rv <= bus.resp_valid;
    end

    task automatic preload(input logic [2:0] idx, input logic [8:0] t, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = idx; pl_tag = t; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] t, input logic [2:0] idx, input logic [31:0] d,
                        input logic is_hit, output int acc);
        exp_t e;
        int   n;
        bus.req_addr = {t, idx};
        bus.req_data = d;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) bound_fail("req_ready_wait");
        if (is_hit) begin
            if (m_hc != '1) m_hc = m_hc + 1'b1;
        end else begin
            if (m_mc != '1) m_mc = m_mc + 1'b1;
        end
        if (is_hit || ALLOC) exp_we++;
        acc   = cyc + 1;
        e.hit = is_hit;
        e.lat = (is_hit || ALLOC) ? 3 : 2;
        e.acc = acc;
        e.hc  = m_hc;
        e.mc  = m_mc;
        exp_q.push_back(e);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.resp_valid) && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) bound_fail("resp_wait");
        chk("data_we_pulses", we_cnt, exp_we);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, prev_acc, n;
        logic [31:0] old4;
        logic [31:0] d5 [0:4];
        d5[0] = 32'h0000_0001; d5[1] = 32'h0000_0022; d5[2] = 32'h0000_0333;
        d5[3] = 32'h0000_4444; d5[4] = 32'h0005_5555;

        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_resp_valid", bus.resp_valid, 1'b0);
        chk("rst_data_we", data_we, 1'b0);
        chk("rst_tag_we", tag_we, 1'b0);
        chk("rst_tag_addr", tag_addr, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        reset_n = 1'b1;

        preload(3'd5, {1'b1, 8'hA3}, 32'h0);
        preload(3'd2, {1'b0, 8'h11}, 32'hCAFE_0002);
        preload(3'd7, {1'b1, 8'h3C}, 32'h0);
        preload(3'd0, {1'b1, 8'h4D}, 32'h0);
        preload(3'd4, {1'b1, 8'h55}, 32'h0BAD_0004);
        preload(3'd1, {1'b1, 8'h77}, 32'h0);

        // Basic hit
        send(8'hA3, 3'd5, 32'hDEADBEEF, 1'b1, acc);
        wait_done();
        chk("t1_data_ram5", data_ram[5], 32'hDEADBEEF);

        // Valid bit clear -> miss
        send(8'h11, 3'd2, 32'h1234_5678, 1'b0, acc);
        wait_done();
        chk("t2_tag_ram2", tag_ram[2], ALLOC ? {1'b1, 8'h11} : {1'b0, 8'h11});
        chk("t2_data_ram2", data_ram[2], ALLOC ? 32'h1234_5678 : 32'hCAFE_0002);

        // Response back-pressure
        bus.resp_ready = 1'b0;
        send(8'hA3, 3'd5, 32'h0F0F_0F0F, 1'b1, acc);
        n = 0;
        while (!bus.resp_valid && n < 20) begin @(negedge clock); n++; end
        if (n >= 20) bound_fail("t3_resp_wait");
        bus.req_valid = 1'b1; bus.req_addr = {8'h4D, 3'd0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("t3_hold_valid", bus.resp_valid, 1'b1);
            chk("t3_hold_hit", bus.resp_hit, 1'b1);
            chk("t3_hold_req_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clock);
        chk("t3_release_valid", bus.resp_valid, 1'b0);
        chk("t3_release_ready", bus.req_ready, 1'b1);
        wait_done();
        chk("t3_data_ram5", data_ram[5], 32'h0F0F_0F0F);

        // Index wrap 7 -> 0, back to back
        send(8'h3C, 3'd7, 32'hAAAA_0007, 1'b1, acc);
        send(8'h4D, 3'd0, 32'hBBBB_0000, 1'b1, acc);
        wait_done();
        chk("t6_data_ram7", data_ram[7], 32'hAAAA_0007);
        chk("t6_data_ram0", data_ram[0], 32'hBBBB_0000);

        // Reset while WRITE is in progress
        old4 = data_ram[4];
        bus.req_addr = {8'h55, 3'd4}; bus.req_data = 32'h7777_7777; bus.req_valid = 1'b1;
        @(negedge clock);
        bus.req_valid = 1'b0;
        n = 0;
        while (!data_we && n < 10) begin @(negedge clock); n++; end
        if (n >= 10) bound_fail("t4_write_wait");
        reset_n = 1'b0;
        @(negedge clock);
        chk("t4_data_we", data_we, 1'b0);
        chk("t4_req_ready", bus.req_ready, 1'b1);
        chk("t4_resp_valid", bus.resp_valid, 1'b0);
        chk("t4_hit_cnt", hit_cnt, 0);
        chk("t4_miss_cnt", miss_cnt, 0);
        chk("t4_data_ram4", data_ram[4], old4);
        chk("t4_we_pulses", we_cnt, exp_we);
        m_hc = '0; m_mc = '0;
        reset_n = 1'b1;
        @(negedge clock);

        // Saturating hit counter, back-to-back turnaround
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(8'h77, 3'd1, d5[i], 1'b1, acc);
            if (i > 0) chk("t5_turnaround", acc - prev_acc, 5);
            prev_acc = acc;
        end
        wait_done();
        chk("t5_hit_cnt_final", hit_cnt, 2'd3);
        chk("t5_miss_cnt_final", miss_cnt, 2'd0);
        chk("t5_data_ram1", data_ram[1], 32'h0005_5555);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
